// File: rtl/result_display_if.sv
// Result display bus: read port toward the 2x2 result buffer plus the
// multiplexed seven-segment drive (segments and digit anodes).
interface result_display_if;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] seg;
    logic [3:0] an;

    // Display block side: issues reads, drives the display.
    modport master (
        output rd_en,
        output rd_addr,
        output seg,
        output an,
        input  rd_data
    );

    // Buffer/display side: answers reads, observes the display.
    modport slave (
        input  rd_en,
        input  rd_addr,
        input  seg,
        input  an,
        output rd_data
    );
endinterface

// File: rtl/result_display.sv
// Result display: on disp_en, reads the four result entries from the buffer,
// then cycles through them page by page on a 4-digit multiplexed display.
// Page p shows "p _ hi lo" (digit3 = page number, digit2 blank).
module result_display #(
    parameter int unsigned SCAN_TICKS = 1000,
    parameter int unsigned PAGE_TICKS = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_en,
    result_display_if.master bus
);

    localparam int unsigned SCAN_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned PAGE_W = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
    localparam logic [6:0]  BLANK  = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                rd_en_q, rd_en_d;
    logic [1:0]          rd_addr_q, rd_addr_d;
    logic [2:0]          ld_cnt_q, ld_cnt_d;
    logic [7:0]          val_q [4];
    logic [7:0]          val_d [4];
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]          digit_q, digit_d;
    logic [PAGE_W-1:0]   page_cnt_q, page_cnt_d;
    logic [1:0]          page_q, page_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;

    // Active-low hex glyph, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = BLANK;
        endcase
        return g;
    endfunction

    // State register and all datapath/output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= 2'd0;
            ld_cnt_q   <= 3'd0;
            scan_cnt_q <= '0;
            digit_q    <= 2'd0;
            page_cnt_q <= '0;
            page_q     <= 2'd0;
            an_q       <= 4'b1111;
            seg_q      <= BLANK;
            for (int i = 0; i < 4; i++) begin
                val_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            ld_cnt_q   <= ld_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            page_cnt_q <= page_cnt_d;
            page_q     <= page_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            for (int i = 0; i < 4; i++) begin
                val_q[i] <= val_d[i];
            end
        end
    end

    // Next-state: dropping disp_en always returns to IDLE; LOAD ends on the
    // edge that captures the last entry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = disp_en ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                if (!disp_en) begin
                    state_d = ST_IDLE;
                end else if (ld_cnt_q == 3'd4) begin
                    state_d = ST_SHOW;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SHOW: state_d = disp_en ? ST_SHOW : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read sequencing, capture and scan/page counters. ld_cnt counts LOAD
    // edges: addresses go out on counts 0..2 (addr 0 is set on entry), and
    // entry k-1 is captured on count k because the buffer has 1-cycle latency.
    always_comb begin
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        ld_cnt_d   = ld_cnt_q;
        scan_cnt_d = scan_cnt_q;
        digit_d    = digit_q;
        page_cnt_d = page_cnt_q;
        page_d     = page_q;
        for (int i = 0; i < 4; i++) begin
            val_d[i] = val_q[i];
        end
        if (!disp_en) begin
            rd_en_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = 2'd0;
                    ld_cnt_d  = 3'd0;
                end
                ST_LOAD: begin
                    ld_cnt_d = ld_cnt_q + 3'd1;
                    if (ld_cnt_q < 3'd3) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = ld_cnt_q[1:0] + 2'd1;
                    end else begin
                        rd_en_d = 1'b0;
                    end
                    case (ld_cnt_q)
                        3'd1:    val_d[0] = bus.rd_data;
                        3'd2:    val_d[1] = bus.rd_data;
                        3'd3:    val_d[2] = bus.rd_data;
                        3'd4:    val_d[3] = bus.rd_data;
                        default: val_d[0] = val_q[0];
                    endcase
                    scan_cnt_d = '0;
                    digit_d    = 2'd0;
                    page_cnt_d = '0;
                    page_d     = 2'd0;
                end
                ST_SHOW: begin
                    if (scan_cnt_q == SCAN_W'(SCAN_TICKS - 1)) begin
                        scan_cnt_d = '0;
                        digit_d    = digit_q + 2'd1;
                    end else begin
                        scan_cnt_d = scan_cnt_q + 1'b1;
                    end
                    if (page_cnt_q == PAGE_W'(PAGE_TICKS - 1)) begin
                        page_cnt_d = '0;
                        page_d     = page_q + 2'd1;
                    end else begin
                        page_cnt_d = page_cnt_q + 1'b1;
                    end
                end
                default: rd_en_d = 1'b0;
            endcase
        end
    end

    // Display drive from next-cycle indices so the registered outputs line
    // up with the digit/page being entered.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = BLANK;
        if (state_d == ST_SHOW) begin
            an_d = ~(4'b0001 << digit_d);
            case (digit_d)
                2'd0:    seg_d = hex_glyph(val_d[page_d][3:0]);
                2'd1:    seg_d = hex_glyph(val_d[page_d][7:4]);
                2'd2:    seg_d = BLANK;
                2'd3:    seg_d = hex_glyph({2'b00, page_d});
                default: seg_d = BLANK;
            endcase
        end else begin
            an_d  = 4'b1111;
            seg_d = BLANK;
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.an      = an_q;
    assign bus.seg     = seg_q;

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 Parameter SCAN_TICKS, default 1000: cycles each digit stays lit; legal range >= 1.
REQ-002 Parameter PAGE_TICKS, default 100000: cycles each result entry stays shown; legal range >= 1.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: system clock (100 MHz).
REQ-005 Port rst, input, 1 bit: synchronous reset, active-high.
REQ-006 Port disp_en, input, 1 bit: run enable from the sequencing controller's display-stage release (1 = run, 0 = idle/blank).
REQ-007 Port rd_en, output, 1 bit: read strobe to the 2x2 result buffer.
REQ-008 Port rd_addr, output, 2 bits: result buffer entry index, 0..3.
REQ-009 Port rd_data, input, 8 bits: buffer read data, valid the cycle after rd_en=1 (1-cycle latency).
REQ-010 Port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Port an, output, 4 bits: digit anodes, active-low one-hot; an[0] = rightmost digit.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, SHOW; all outputs SHALL be registered.
REQ-013 In IDLE, the block SHALL drive rd_en=0, an=4'b1111, and seg=7'b1111111.
REQ-014 IDLE->LOAD SHALL occur at the edge sampling disp_en=1; at that edge rd_en<=1 and rd_addr<=0.
REQ-015 In LOAD, the block SHALL issue rd_addr 0,1,2,3 on 4 consecutive cycles with rd_en=1, then rd_en<=0; rd_addr SHALL hold 3 afterwards.
REQ-016 Entry i SHALL be captured from rd_data at the edge one cycle after addr i was presented, into internal register val[i].
REQ-017 LOAD->SHOW SHALL occur at the edge capturing val[3], i.e. 5 edges after the disp_en sample edge.
REQ-018 On entering SHOW, the scan counter, digit index and page index SHALL all be 0.
REQ-019 The digit index SHALL advance 0->1->2->3->0 every SCAN_TICKS cycles.
REQ-020 The page index SHALL advance 0->1->2->3->0 every PAGE_TICKS cycles; the two counters SHALL be independent.
REQ-021 In SHOW, for page p the block SHALL show: digit3 = hex(p), digit2 = blank, digit1 = hex(val[p][7:4]), digit0 = hex(val[p][3:0]).
REQ-022 Only the anode of the current digit SHALL be low, with seg set to that digit's glyph.
REQ-023 Hex glyphs SHALL use standard 7-seg patterns; e.g. 0=7'b1000000, 3=7'b0110000, A=7'b0001000, F=7'b0001110, 8=7'b0000000; blank=7'b1111111.
REQ-024 disp_en=0 sampled in LOAD or SHOW SHALL force IDLE at that edge: rd_en<=0, blank outputs; partially loaded values are discarded.
REQ-025 Re-assertion of disp_en SHALL always perform a full 4-entry reload from addr 0.
REQ-026 val[] SHALL NOT change during SHOW; rd_data is ignored outside the capture slots.

Reset
REQ-027 rst=1 at an edge SHALL set state=IDLE, rd_en=0, rd_addr=0, an=4'b1111, seg=7'b1111111, and all counters, indices and val[0..3] to 0, regardless of state, and SHALL override disp_en.
REQ-028 After rst deasserts with disp_en already 1, the block SHALL enter LOAD at the first edge with rst=0.

Verification (SCAN_TICKS=4, PAGE_TICKS=64)
REQ-029 Scenario reset: rst=1 for 3 cycles with disp_en=1 -> rd_en=0, an=1111, seg=1111111 throughout.
REQ-030 Scenario load: buffer = {3A,FF,00,81}, disp_en rises -> rd_en high exactly 4 cycles with addr 0..3; SHOW entered 5 edges later; val = {3A,FF,00,81}.
REQ-031 Scenario scan on page 0 -> an 1110/seg A(0001000), 1101/3(0110000), 1011/blank, 0111/0(1000000), each for 4 cycles, then repeats.
REQ-032 Scenario page wrap -> after 64 cycles page 1 shows digits F,F and index 1; after 256 cycles page 0 (3A) again.
REQ-033 Scenario abort: disp_en dropped on the 2nd LOAD cycle -> IDLE next edge, rd_en=0, blank; re-raise -> fresh reads from addr 0.
REQ-034 Scenario rst=1 mid-SHOW -> blank outputs next edge; with disp_en=1 after release, full reload and SHOW from page 0, digit 0.
